// File: rtl/passive_alarm_ctrl_if.sv
// Signal bundle for passive_alarm_ctrl.
//   master : the vehicle side. It drives the ignition, door, lights and disarm
//            inputs and observes the state and indicator outputs.
//   slave  : the controller side. It receives those inputs and drives
//            State, ArmedLed, Chime, Siren and PassiveSignal.
interface passive_alarm_ctrl_if;
    logic       IgnitionSignalOn;
    logic       OpenDoorSign;
    logic       CarLightsOnSign;
    logic       Disarm;
    logic [2:0] State;
    logic       ArmedLed;
    logic       Chime;
    logic       Siren;
    logic       PassiveSignal;

    modport master (
        output IgnitionSignalOn, OpenDoorSign, CarLightsOnSign, Disarm,
        input  State, ArmedLed, Chime, Siren, PassiveSignal
    );

    modport slave (
        input  IgnitionSignalOn, OpenDoorSign, CarLightsOnSign, Disarm,
        output State, ArmedLed, Chime, Siren, PassiveSignal
    );
endinterface

// File: rtl/passive_alarm_ctrl.sv
// Passive vehicle alarm sequencer.
// The controller arms itself after the driver closes the door with the
// ignition off. A door opened while armed starts an entry-delay countdown
// with a chime. When that countdown expires, the siren sounds for a bounded
// time and the controller then returns to ARMED. Ignition or a Disarm pulse
// always wins and returns the controller to DISARMED. A separate registered
// reminder warns that the lights were left on.
// Ports:
//   Clock : rising-edge clock.
//   Reset : asynchronous, active-high reset.
//   bus   : slave side of passive_alarm_ctrl_if. Its inputs are ignition,
//           door, lights and disarm. Its outputs are State, ArmedLed, Chime,
//           Siren and PassiveSignal.
module passive_alarm_ctrl #(
    parameter int CNT_W       = 16,
    parameter int ARM_DELAY   = 8,
    parameter int ENTRY_DELAY = 6,
    parameter int ALARM_TIME  = 12
) (
    input  logic                 Clock,
    input  logic                 Reset,
    passive_alarm_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        DISARMED = 3'd0,
        ARMING   = 3'd1,
        ARMED    = 3'd2,
        ENTRY    = 3'd3,
        ALARM    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ARM_LOAD   = CNT_W'(ARM_DELAY - 1);
    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
    localparam logic [CNT_W-1:0] ALARM_LOAD = CNT_W'(ALARM_TIME - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             door_q;
    logic             left_q, left_d;
    logic             armed_q, chime_q, siren_q, passive_q;

    logic door_rise, door_fall, cnt_zero;

    assign door_rise = bus.OpenDoorSign & ~door_q;
    assign door_fall = ~bus.OpenDoorSign & door_q;
    assign cnt_zero  = (cnt_q == '0);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= DISARMED;
            cnt_q     <= '0;
            door_q    <= 1'b0;
            left_q    <= 1'b0;
            armed_q   <= 1'b0;
            chime_q   <= 1'b0;
            siren_q   <= 1'b0;
            passive_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            door_q    <= bus.OpenDoorSign;
            left_q    <= left_d;
            // The indicators decode the next state, so they are aligned with State.
            armed_q   <= (state_d == ARMED) || (state_d == ENTRY) || (state_d == ALARM);
            chime_q   <= (state_d == ENTRY);
            siren_q   <= (state_d == ALARM);
            passive_q <= bus.CarLightsOnSign & bus.OpenDoorSign & ~bus.IgnitionSignalOn;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.IgnitionSignalOn || bus.Disarm) begin
            state_d = DISARMED;
        end else begin
            unique case (state_q)
                DISARMED: begin
                    if (!bus.OpenDoorSign && (left_q || door_fall)) begin
                        state_d = ARMING;
                        cnt_d   = ARM_LOAD;
                    end
                end
                ARMING: begin
                    if (bus.OpenDoorSign)  state_d = DISARMED;
                    else if (cnt_zero)     state_d = ARMED;
                    else                   cnt_d   = cnt_q - CNT_W'(1);
                end
                ARMED: begin
                    if (door_rise) begin
                        state_d = ENTRY;
                        cnt_d   = ENTRY_LOAD;
                    end
                end
                ENTRY: begin
                    // Closing the door again does not cancel the entry delay.
                    if (cnt_zero) begin
                        state_d = ALARM;
                        cnt_d   = ALARM_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ALARM: begin
                    // A door still open at timeout does not retrigger.
                    // Only a fresh DoorRise in ARMED starts ENTRY again.
                    if (cnt_zero) state_d = ARMED;
                    else          cnt_d   = cnt_q - CNT_W'(1);
                end
                default: state_d = DISARMED;
            endcase
        end
    end

    // LeftFlag holds a door close that was seen in DISARMED but could not
    // arm the system on that edge, for example because Disarm was also high.
    always_comb begin
        left_d = left_q;
        if (state_q == DISARMED && !bus.IgnitionSignalOn && door_fall)
            left_d = 1'b1;
        if (state_d == DISARMED && state_q != DISARMED)
            left_d = 1'b0;
    end

    assign bus.State         = state_q;
    assign bus.ArmedLed      = armed_q;
    assign bus.Chime         = chime_q;
    assign bus.Siren         = siren_q;
    assign bus.PassiveSignal = passive_q;

endmodule

// File: tb/tb_passive_alarm_ctrl.sv
module tb_passive_alarm_ctrl;
    localparam int ARM_DELAY   = 8;
    localparam int ENTRY_DELAY = 6;
    localparam int ALARM_TIME  = 12;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    passive_alarm_ctrl_if bus();

    passive_alarm_ctrl #(
        .CNT_W(16), .ARM_DELAY(ARM_DELAY), .ENTRY_DELAY(ENTRY_DELAY), .ALARM_TIME(ALARM_TIME)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus(bus.slave)
    );

    always #5 Clock = ~Clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: a state number plus the count of cycles spent in that state.
    int m_state;
    int m_elapsed;
    bit m_dq, m_left, m_pass;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_elapsed = 0; m_dq = 0; m_left = 0; m_pass = 0;
    endtask

    task automatic model_edge(input bit ign, input bit door, input bit lights, input bit dis);
        bit rise, fall;
        int ns, done;
        rise = door && !m_dq;
        fall = !door && m_dq;
        done = m_elapsed + 1;
        ns = m_state;
        if (ign || dis) ns = 0;
        else begin
            case (m_state)
                0: if (!door && (m_left || fall)) ns = 1;
                1: if (door) ns = 0; else if (done == ARM_DELAY) ns = 2;
                2: if (rise) ns = 3;
                3: if (done == ENTRY_DELAY) ns = 4;
                4: if (done == ALARM_TIME) ns = 2;
                default: ns = 0;
            endcase
        end
        if (m_state == 0 && !ign && fall) m_left = 1;
        if (ns == 0 && m_state != 0) m_left = 0;
        m_elapsed = (ns != m_state) ? 0 : done;
        m_state = ns;
        m_dq = door;
        m_pass = lights && door && !ign;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".State"},    8'(bus.State),         8'(m_state));
        chk({tag, ".ArmedLed"}, 8'(bus.ArmedLed),      8'(m_state >= 2 && m_state <= 4));
        chk({tag, ".Chime"},    8'(bus.Chime),         8'(m_state == 3));
        chk({tag, ".Siren"},    8'(bus.Siren),         8'(m_state == 4));
        chk({tag, ".Passive"},  8'(bus.PassiveSignal), 8'(m_pass));
    endtask

    // This task is called at the edge plus 1, away from the active edge.
    // It drives the inputs, waits for one rising edge, updates the model and
    // then checks every output.
    task automatic step(input string tag, input bit ign, input bit door, input bit lights, input bit dis);
        bus.IgnitionSignalOn = ign;
        bus.OpenDoorSign     = door;
        bus.CarLightsOnSign  = lights;
        bus.Disarm           = dis;
        @(posedge Clock);
        model_edge(ign, door, lights, dis);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        bit door, lights, ign, dis;
        bus.IgnitionSignalOn = 0;
        bus.OpenDoorSign     = 0;
        bus.CarLightsOnSign  = 0;
        bus.Disarm           = 0;
        model_reset();
        #1;
        check_outputs("reset");
        @(posedge Clock); #1;
        Reset = 0;

        // Arming: door open for 3 cycles, then closed.
        repeat (3) step("arm_open", 0, 1, 0, 0);
        step("arm_fall", 0, 0, 0, 0);
        chk("arm_start", 8'(bus.State), 8'd1);
        repeat (ARM_DELAY - 1) step("arming", 0, 0, 0, 0);
        chk("arm_last", 8'(bus.State), 8'd1);
        step("armed", 0, 0, 0, 0);
        chk("armed_state", 8'(bus.State), 8'd2);
        chk("armed_led", 8'(bus.ArmedLed), 8'd1);

        // Full alarm sequence with the door held open throughout.
        repeat (ENTRY_DELAY) step("entry", 0, 1, 0, 0);
        chk("entry_chime", 8'(bus.Chime), 8'd1);
        repeat (ALARM_TIME) step("alarm", 0, 1, 0, 0);
        chk("alarm_siren", 8'(bus.Siren), 8'd1);
        step("alarm_done", 0, 1, 0, 0);
        chk("back_armed", 8'(bus.State), 8'd2);
        chk("siren_off", 8'(bus.Siren), 8'd0);
        repeat (6) step("held_open", 0, 1, 0, 0);
        chk("no_retrigger", 8'(bus.State), 8'd2);

        // Disarm pulse on ENTRY cycle 3, then a door close re-arms.
        repeat (2) step("close", 0, 0, 0, 0);
        repeat (3) step("entry2", 0, 1, 0, 0);
        step("disarm", 0, 1, 0, 1);
        chk("disarm_state", 8'(bus.State), 8'd0);
        chk("disarm_chime", 8'(bus.Chime), 8'd0);
        step("rearm_fall", 0, 0, 0, 0);
        chk("rearm", 8'(bus.State), 8'd1);

        // Door opened during ARMING at Cnt=4, then the full arming restarts.
        repeat (3) step("arming2", 0, 0, 0, 0);
        step("abort", 0, 1, 0, 0);
        chk("abort_state", 8'(bus.State), 8'd0);
        repeat (ARM_DELAY + 1) step("rearm2", 0, 0, 0, 0);
        chk("rearm2_armed", 8'(bus.State), 8'd2);

        // Ignition during ALARM.
        repeat (ENTRY_DELAY + 3) step("to_alarm", 0, 1, 0, 0);
        chk("in_alarm", 8'(bus.State), 8'd4);
        step("ign_alarm", 1, 1, 0, 0);
        chk("ign_siren", 8'(bus.Siren), 8'd0);
        chk("ign_state", 8'(bus.State), 8'd0);

        // Lights reminder.
        step("lights_on", 0, 1, 1, 0);
        chk("passive_on", 8'(bus.PassiveSignal), 8'd1);
        step("lights_ign", 1, 1, 1, 0);
        chk("passive_off", 8'(bus.PassiveSignal), 8'd0);

        // Asynchronous reset between edges during ALARM.
        step("door_open", 0, 1, 0, 0);
        repeat (ARM_DELAY + 1) step("arm3", 0, 0, 0, 0);
        repeat (ENTRY_DELAY + 4) step("to_alarm3", 0, 1, 0, 0);
        chk("alarm3", 8'(bus.Siren), 8'd1);
        #2;
        Reset = 1;
        #1;
        model_reset();
        check_outputs("async_reset");
        @(posedge Clock); #1;
        Reset = 0;
        step("post_reset", 0, 1, 0, 0);

        // Randomized phase checked against the model.
        door = 1; lights = 0;
        for (int i = 0; i < 800; i++) begin
            ign = ($urandom_range(0, 31) == 0);
            dis = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 5) == 0) door = !door;
            lights = 1'($urandom_range(0, 1));
            step("rand", ign, door, lights, dis);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
